// File: rtl/img_rx_pkg.sv
// Shared types and helpers for the UART-to-RAM image writer.
package img_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WR   = 2'd2
    } state_t;

    function automatic int data_w(input int bytes_per_word);
        return BYTE_W * bytes_per_word;
    endfunction

endpackage

// File: rtl/img_rx_timeout.sv
// Inter-byte gap counter: clears on i_clr, counts while i_en, pulses o_expire
// on the cycle the count reaches TIMEOUT_CYC-1.
module img_rx_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit    = i_en && !i_clr && (r_cnt == LAST);
    assign o_expire = w_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_hit) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/img_rx_pack_wr.sv
// Packs received UART bytes into pixel words and writes them to the frame RAM.
// Define IMG_RX_TIMEOUT_EN to discard a partial word after an inter-byte gap.
module img_rx_pack_wr
    import img_rx_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 2,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned FRAME_WORDS    = 16384,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYC    = 50000,
    localparam int unsigned DATA_W        = data_w(BYTES_PER_WORD)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              Rx_Done,
    input  logic              soft_clr,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              partial_drop
);

    localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_t            r_state;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_addr;
    logic [DATA_W-1:0] w_word;
    logic              w_accept;
    logic              w_last;
    logic              w_addr_end;
    logic              w_expire;

    assign w_accept   = Rx_Done && !soft_clr && !w_expire;
    assign w_last     = (r_byte_idx == LAST_IDX);
    assign w_addr_end = (r_word_addr == END_ADDR);

    // Only the bytes still waiting for completion are stored; the incoming
    // byte is merged combinationally, giving the same word as a full-width shift.
    if (BYTES_PER_WORD == 1) begin : g_nopack
        assign w_word = rx_data;
    end else begin : g_pack
        logic [DATA_W-BYTE_W-1:0] r_pack;

        if (MSB_FIRST) begin : g_msb
            assign w_word = {r_pack, rx_data};
        end else begin : g_lsb
            assign w_word = {rx_data, r_pack};
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_pack <= '0;
            end else if (w_accept) begin
                r_pack <= MSB_FIRST ? w_word[DATA_W-BYTE_W-1:0] : w_word[DATA_W-1:BYTE_W];
            end
        end
    end

`ifdef IMG_RX_TIMEOUT_EN
    img_rx_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_clr    (Rx_Done),
        .i_en     (r_state == S_FILL),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= '0;
            r_word_addr  <= '0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            partial_drop <= 1'b0;
        end else begin
            ram_wr_en    <= 1'b0;
            frame_done   <= 1'b0;
            partial_drop <= 1'b0;
            if (soft_clr) begin
                partial_drop <= (r_byte_idx != '0) || (r_state == S_FILL);
                r_state      <= S_IDLE;
                r_byte_idx   <= '0;
                r_word_addr  <= '0;
            end else if (w_expire) begin
                partial_drop <= 1'b1;
                r_state      <= S_IDLE;
                r_byte_idx   <= '0;
            end else if (Rx_Done) begin
                if (w_last) begin
                    // Address advances as the write issues; the write itself uses the old value.
                    r_state     <= S_WR;
                    r_byte_idx  <= '0;
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= r_word_addr;
                    ram_wr_data <= w_word;
                    frame_done  <= w_addr_end;
                    r_word_addr <= w_addr_end ? '0 : r_word_addr + 1'b1;
                    if (w_addr_end) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    r_state    <= S_FILL;
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end else if (r_state == S_WR) begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_img_rx_pack_wr.sv
// Bench for img_rx_pack_wr: two configurations checked against a byte-queue
// reference model, plus directed vector tables and corner-case sequences.
module tb_img_rx_pack_wr;

`ifdef IMG_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 100;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Rx_Done = 1'b0;
    logic        soft_clr = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        d0_wr, d0_fd, d0_pd;
    logic [3:0]  d0_addr;
    logic [15:0] d0_data;
    logic [7:0]  d0_fc;
    logic        d1_wr, d1_fd, d1_pd;
    logic [3:0]  d1_addr;
    logic [23:0] d1_data;
    logic [7:0]  d1_fc;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    img_rx_pack_wr #(
        .BYTES_PER_WORD(2), .ADDR_W(4), .FRAME_WORDS(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(TO_CYC)
    ) u_dut0 (
        .Clk(Clk), .Reset(Reset), .rx_data(rx_data), .Rx_Done(Rx_Done), .soft_clr(soft_clr),
        .ram_wr_en(d0_wr), .ram_wr_addr(d0_addr), .ram_wr_data(d0_data),
        .frame_done(d0_fd), .frame_cnt(d0_fc), .partial_drop(d0_pd)
    );

    img_rx_pack_wr #(
        .BYTES_PER_WORD(3), .ADDR_W(4), .FRAME_WORDS(5), .MSB_FIRST(1'b0), .TIMEOUT_CYC(TO_CYC)
    ) u_dut1 (
        .Clk(Clk), .Reset(Reset), .rx_data(rx_data), .Rx_Done(Rx_Done), .soft_clr(soft_clr),
        .ram_wr_en(d1_wr), .ram_wr_addr(d1_addr), .ram_wr_data(d1_data),
        .frame_done(d1_fd), .frame_cnt(d1_fc), .partial_drop(d1_pd)
    );

    // Reference model: per-instance queue of pending bytes and write bookkeeping.
    int          bpw [2] = '{2, 3};
    bit          msb [2] = '{1'b1, 1'b0};
    int          fw  [2] = '{4, 5};
    int          m_n [2];
    logic [7:0]  m_b [2][4];
    int          m_addr [2];
    int          m_gap [2];
    logic [7:0]  m_fc [2];
    logic        m_wr [2], m_fd [2], m_pd [2];
    logic [31:0] m_data [2];
    int          m_waddr [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_addr[k] = 0; m_gap[k] = 0; m_fc[k] = 8'h00;
            m_wr[k] = 1'b0; m_fd[k] = 1'b0; m_pd[k] = 1'b0;
            m_data[k] = 32'h0; m_waddr[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k, input bit rx, input logic [7:0] d, input bit clr);
        logic [31:0] word;
        m_wr[k] = 1'b0; m_fd[k] = 1'b0; m_pd[k] = 1'b0;
        if (clr) begin
            m_pd[k]   = (m_n[k] != 0);
            m_n[k]    = 0;
            m_addr[k] = 0;
        end else if (rx) begin
            m_gap[k] = 0;
            m_b[k][m_n[k]] = d;
            m_n[k]++;
            if (m_n[k] == bpw[k]) begin
                word = 32'h0;
                for (int i = 0; i < bpw[k]; i++) begin
                    if (msb[k]) word = (word << 8) | 32'(m_b[k][i]);
                    else        word = word | (32'(m_b[k][i]) << (8 * i));
                end
                m_wr[k]    = 1'b1;
                m_data[k]  = word;
                m_waddr[k] = m_addr[k];
                m_fd[k]    = (m_addr[k] == fw[k] - 1);
                if (m_fd[k]) m_fc[k] = m_fc[k] + 8'd1;
                m_addr[k] = (m_addr[k] + 1) % fw[k];
                m_n[k]    = 0;
            end
        end else if (TO_EN && m_n[k] != 0) begin
            m_gap[k]++;
            if (m_gap[k] == TO_CYC) begin
                m_pd[k] = 1'b1;
                m_n[k]  = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input logic wr, input logic [3:0] addr,
                               input logic [31:0] data, input logic fd,
                               input logic [7:0] fc, input logic pd);
        string p;
        p = (k == 0) ? "d0" : "d1";
        check({p, "_wr_en"},   32'(wr),   32'(m_wr[k]));
        check({p, "_addr"},    32'(addr), 32'(m_waddr[k]));
        check({p, "_data"},    data,      m_data[k]);
        check({p, "_fdone"},   32'(fd),   32'(m_fd[k]));
        check({p, "_fcnt"},    32'(fc),   32'(m_fc[k]));
        check({p, "_pdrop"},   32'(pd),   32'(m_pd[k]));
    endtask

    task automatic tick(input bit rx, input logic [7:0] d, input bit clr);
        @(negedge Clk);
        Rx_Done = rx; rx_data = d; soft_clr = clr;
        @(posedge Clk);
        model_step(0, rx, d, clr);
        model_step(1, rx, d, clr);
        #1;
        compare_dut(0, d0_wr, d0_addr, 32'(d0_data), d0_fd, d0_fc, d0_pd);
        compare_dut(1, d1_wr, d1_addr, 32'(d1_data), d1_fd, d1_fc, d1_pd);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; Rx_Done = 1'b0; soft_clr = 1'b0; rx_data = 8'h00;
        @(negedge Clk);
        check("rst_d0_wr",   32'(d0_wr),   32'h0);
        check("rst_d0_addr", 32'(d0_addr), 32'h0);
        check("rst_d0_data", 32'(d0_data), 32'h0);
        check("rst_d0_fd",   32'(d0_fd),   32'h0);
        check("rst_d0_fc",   32'(d0_fc),   32'h0);
        check("rst_d0_pd",   32'(d0_pd),   32'h0);
        check("rst_d1_wr",   32'(d1_wr),   32'h0);
        check("rst_d1_data", 32'(d1_data), 32'h0);
        check("rst_d1_fc",   32'(d1_fc),   32'h0);
        model_reset();
        Reset = 1'b0;
    endtask

    typedef struct {
        bit          rx;
        logic [7:0]  d;
        bit          clr;
        bit          e_wr;
        logic [3:0]  e_addr;
        logic [15:0] e_data;
        bit          e_pd;
    } vec_t;

    initial begin
        vec_t tbl [18];
        int   fdc, wcnt, pdc;

        // Directed vectors for the 2-byte MSB-first instance (FRAME_WORDS=4).
        tbl[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 8'h34, 1'b0, 1'b1, 4'h0, 16'h1234, 1'b0};
        tbl[2]  = '{1'b1, 8'h56, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 8'h78, 1'b0, 1'b1, 4'h1, 16'h5678, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 8'h22, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 4'h0, 16'h3344, 1'b0};
        tbl[9]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[10] = '{1'b1, 8'hA4, 1'b0, 1'b1, 4'h1, 16'hA3A4, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[14] = '{1'b1, 8'h02, 1'b0, 1'b1, 4'h0, 16'h0102, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[16] = '{1'b1, 8'h03, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[17] = '{1'b1, 8'h04, 1'b0, 1'b1, 4'h0, 16'h0304, 1'b0};

        model_reset();
        do_reset();

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].rx, tbl[i].d, tbl[i].clr);
            check($sformatf("tbl%0d_wr", i), 32'(d0_wr), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                check($sformatf("tbl%0d_addr", i), 32'(d0_addr), 32'(tbl[i].e_addr));
                check($sformatf("tbl%0d_data", i), 32'(d0_data), 32'(tbl[i].e_data));
            end
            check($sformatf("tbl%0d_pd", i), 32'(d0_pd), 32'(tbl[i].e_pd));
        end
        tick(1'b0, 8'h00, 1'b0);

        // 3-byte LSB-first word.
        do_reset();
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        tick(1'b1, 8'hCC, 1'b0);
        check("lsb3_wr",   32'(d1_wr),   32'h1);
        check("lsb3_addr", 32'(d1_addr), 32'h0);
        check("lsb3_data", 32'(d1_data), 32'hCCBBAA);
        tick(1'b0, 8'h00, 1'b0);

        // Ten words through a four-word frame.
        do_reset();
        fdc = 0; wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 8'(i + 1), 1'b0);
            if (d0_wr) begin
                check("frame_addr_seq", 32'(d0_addr), 32'(wcnt % 4));
                wcnt++;
            end
            if (d0_fd) fdc++;
        end
        tick(1'b0, 8'h00, 1'b0);
        check("frame_words",  32'(wcnt),    32'd10);
        check("frame_dones",  32'(fdc),     32'd2);
        check("frame_cnt",    32'(d0_fc),   32'd2);
        check("frame_lastad", 32'(d0_addr), 32'd1);

        // Long gap after a single byte.
        do_reset();
        tick(1'b1, 8'h55, 1'b0);
        pdc = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (d0_pd) pdc++;
        end
        tick(1'b1, 8'h66, 1'b0);
        tick(1'b1, 8'h77, 1'b0);
        check("gap_pdrops", 32'(pdc),     TO_EN ? 32'd1 : 32'd0);
        check("gap_data",   32'(d0_data), TO_EN ? 32'h6677 : 32'h5566);
        check("gap_addr",   32'(d0_addr), 32'h0);
        tick(1'b0, 8'h00, 1'b0);

        // Reset in the middle of a word.
        do_reset();
        tick(1'b1, 8'hC1, 1'b0);
        tick(1'b1, 8'hC2, 1'b0);
        tick(1'b1, 8'hD1, 1'b0);
        do_reset();
        tick(1'b1, 8'hE1, 1'b0);
        tick(1'b1, 8'hE2, 1'b0);
        check("midrst_wr",   32'(d0_wr),   32'h1);
        check("midrst_addr", 32'(d0_addr), 32'h0);
        check("midrst_data", 32'(d0_data), 32'hE1E2);
        tick(1'b0, 8'h00, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int j = 0; j < 110; j++) tick(1'b0, 8'h00, 1'b0);
            end
            tick($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 3);
        end
        tick(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
